// File: rtl/exec_command_sequencer.sv
// ---------------------------------------------------------------------------
// exec_command_sequencer
//
// Control-side driver for the execution-engine handshake FSMs. One command
// carries a stage mask. The sequencer kicks the start FSM, waits for it to
// load parameters, then pulses each requested stage's start input in fixed
// order (bit 0 first). Each stage must answer with success or fail before
// the next stage is started. The command result goes to the done FSM or the
// error FSM, and that handshake is closed with control_ack.
//
// Every waiting phase (FETCH, WAIT, ACK_OK, ACK_ERR) has a watchdog of
// TIMEOUT cycles. If the watchdog expires, the command is aborted.
//
// Ports
//   clk                        single clock, rising edge
//   rst                        synchronous, active-high reset
//   cmd_valid                  command present (sampled only when idle)
//   cmd_stage_mask[7:0]        stages required by the command
//   cmd_ready                  sequencer idle, can accept a command
//   start_processing           one-cycle pulse to the start FSM
//   start_processing_complete  start FSM has loaded parameters
//   stage_start[7:0]           one-hot, one-cycle start pulse per stage
//   stage_success[7:0]         per-stage success/complete pulse
//   stage_fail[7:0]            per-stage fail pulse
//   command_succeeded          one-cycle pulse to the done FSM
//   command_failed             one-cycle pulse to the error FSM
//   execution_complete_signal  level from the done FSM
//   execution_error_signal     level from the error FSM
//   control_ack                one-cycle acknowledge to the done/error FSMs
//   busy                       high whenever not idle
//   fail_stage[2:0]            failing/timed-out stage; 7 for a FETCH failure
//   fail_timeout               last failure was a watchdog timeout
//   stages_done[7:0]           stages of this command that succeeded
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module exec_command_sequencer #(
    parameter int TIMEOUT = 1000,
    parameter int NSTAGE  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [NSTAGE-1:0] cmd_stage_mask,
    output logic              cmd_ready,
    output logic              start_processing,
    input  logic              start_processing_complete,
    output logic [NSTAGE-1:0] stage_start,
    input  logic [NSTAGE-1:0] stage_success,
    input  logic [NSTAGE-1:0] stage_fail,
    output logic              command_succeeded,
    output logic              command_failed,
    input  logic              execution_complete_signal,
    input  logic              execution_error_signal,
    output logic              control_ack,
    output logic              busy,
    output logic [2:0]        fail_stage,
    output logic              fail_timeout,
    output logic [NSTAGE-1:0] stages_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SELECT,
        S_WAIT,
        S_REPORT_OK,
        S_REPORT_ERR,
        S_ACK_OK,
        S_ACK_ERR
    } state_t;

    // The counter compares against the last legal waiting cycle. It starts
    // at 0 on entry, so a phase may last at most TIMEOUT cycles.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [15:0]         wdog_q, wdog_d;
    logic [NSTAGE-1:0]   pending_q, pending_d;
    logic [2:0]          idx_q, idx_d;
    logic [NSTAGE-1:0]   stages_done_q, stages_done_d;
    logic [2:0]          fail_stage_q, fail_stage_d;
    logic                fail_timeout_q, fail_timeout_d;
    logic                start_processing_q, start_processing_d;
    logic [NSTAGE-1:0]   stage_start_q, stage_start_d;
    logic                command_succeeded_q, command_succeeded_d;
    logic                command_failed_q, command_failed_d;
    logic                control_ack_q, control_ack_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic                wdog_expired;
    logic                waiting_phase;
    logic [2:0]          lowest_idx;
    logic [NSTAGE-1:0]   lowest_oh;
    logic [NSTAGE-1:0]   lane_sel;
    logic                sel_success;
    logic                sel_fail;

    assign wdog_expired  = (wdog_q == WDOG_LAST);
    assign waiting_phase = (state_q == S_FETCH)  || (state_q == S_WAIT) ||
                           (state_q == S_ACK_OK) || (state_q == S_ACK_ERR);

    // Lowest set bit of the pending mask. Scanning from the top means the
    // last hit is the lowest index, which gives bit-0-first start order.
    always_comb begin
        lowest_idx = 3'd0;
        lowest_oh  = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx   = 3'(i);
                lowest_oh    = '0;
                lowest_oh[i] = 1'b1;
            end
        end
    end

    // Only the lane that was started is watched. Responses on the other
    // lanes are masked off here.
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_lane_sel
        assign lane_sel[gi] = (idx_q == 3'(gi));
    end

    assign sel_success = |(stage_success & lane_sel);
    assign sel_fail    = |(stage_fail & lane_sel);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        pending_d          = pending_q;
        idx_d              = idx_q;
        stages_done_d      = stages_done_q;
        fail_stage_d       = fail_stage_q;
        fail_timeout_d     = fail_timeout_q;
        start_processing_d = 1'b0;
        stage_start_d      = '0;
        control_ack_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pending_d          = cmd_stage_mask;
                    stages_done_d      = '0;
                    fail_stage_d       = 3'd0;
                    fail_timeout_d     = 1'b0;
                    start_processing_d = 1'b1;
                    state_d            = S_FETCH;
                end
            end

            S_FETCH: begin
                // A completion arriving in the expiry cycle still counts.
                if (start_processing_complete) begin
                    state_d = S_SELECT;
                end else if (wdog_expired) begin
                    fail_stage_d   = 3'd7;
                    fail_timeout_d = 1'b1;
                    state_d        = S_REPORT_ERR;
                end
            end

            S_SELECT: begin
                if (pending_q == '0) begin
                    state_d = S_REPORT_OK;
                end else begin
                    idx_d         = lowest_idx;
                    pending_d     = pending_q & ~lowest_oh;
                    stage_start_d = lowest_oh;
                    state_d       = S_WAIT;
                end
            end

            S_WAIT: begin
                // Fail wins over a simultaneous success. Any response wins
                // over the watchdog.
                if (sel_fail) begin
                    fail_stage_d   = idx_q;
                    fail_timeout_d = 1'b0;
                    state_d        = S_REPORT_ERR;
                end else if (sel_success) begin
                    stages_done_d = stages_done_q | lane_sel;
                    state_d       = S_SELECT;
                end else if (wdog_expired) begin
                    fail_stage_d   = idx_q;
                    fail_timeout_d = 1'b1;
                    state_d        = S_REPORT_ERR;
                end
            end

            S_REPORT_OK: begin
                state_d = S_ACK_OK;
            end

            S_REPORT_ERR: begin
                state_d = S_ACK_ERR;
            end

            S_ACK_OK: begin
                if (execution_complete_signal) begin
                    control_ack_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (wdog_expired) begin
                    // The done FSM never answered. Drop back without
                    // acknowledging and keep the failing stage as it was.
                    fail_timeout_d = 1'b1;
                    state_d        = S_IDLE;
                end
            end

            S_ACK_ERR: begin
                if (execution_error_signal) begin
                    control_ack_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (wdog_expired) begin
                    fail_timeout_d = 1'b1;
                    state_d        = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The report states last exactly one cycle, so their pulses can be
        // derived from the state being entered.
        command_succeeded_d = (state_d == S_REPORT_OK);
        command_failed_d    = (state_d == S_REPORT_ERR);
        cmd_ready_d         = (state_d == S_IDLE);
        busy_d              = (state_d != S_IDLE);

        // Waiting phases are never re-entered from themselves. Any state
        // change therefore marks a fresh phase, and the counter restarts.
        if (state_d != state_q) begin
            wdog_d = 16'd0;
        end else if (waiting_phase) begin
            wdog_d = wdog_q + 16'd1;
        end else begin
            wdog_d = wdog_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= S_IDLE;
            wdog_q              <= 16'd0;
            pending_q           <= '0;
            idx_q               <= 3'd0;
            stages_done_q       <= '0;
            fail_stage_q        <= 3'd0;
            fail_timeout_q      <= 1'b0;
            start_processing_q  <= 1'b0;
            stage_start_q       <= '0;
            command_succeeded_q <= 1'b0;
            command_failed_q    <= 1'b0;
            control_ack_q       <= 1'b0;
            cmd_ready_q         <= 1'b1;
            busy_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            wdog_q              <= wdog_d;
            pending_q           <= pending_d;
            idx_q               <= idx_d;
            stages_done_q       <= stages_done_d;
            fail_stage_q        <= fail_stage_d;
            fail_timeout_q      <= fail_timeout_d;
            start_processing_q  <= start_processing_d;
            stage_start_q       <= stage_start_d;
            command_succeeded_q <= command_succeeded_d;
            command_failed_q    <= command_failed_d;
            control_ack_q       <= control_ack_d;
            cmd_ready_q         <= cmd_ready_d;
            busy_q              <= busy_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign start_processing  = start_processing_q;
    assign stage_start       = stage_start_q;
    assign command_succeeded = command_succeeded_q;
    assign command_failed    = command_failed_q;
    assign control_ack       = control_ack_q;
    assign busy              = busy_q;
    assign fail_stage        = fail_stage_q;
    assign fail_timeout      = fail_timeout_q;
    assign stages_done       = stages_done_q;

endmodule

// File: doc/exec_command_sequencer.md
Name: exec_command_sequencer

Overview:
- Control-side driver for the execution-engine handshake FSMs (idle, start, authorization, NVM, VM, RNG, asym, sym, hash, keygen, done, error).
- Accepts one command carrying a stage mask and pulses each requested stage's start input in fixed priority order.
- Collects each stage's success/fail response, reports the command result through the done or error FSM, and closes that handshake with control_ack.
- Enforces a per-phase watchdog timeout.

Parameters:
- TIMEOUT, 1000: cycles allowed in any waiting phase before an abort; range 2..65535.
- NSTAGE, 8: number of stage lanes. Fixed at 8: bit 0 auth, 1 nvm, 2 vm, 3 rng, 4 asym, 5 sym, 6 hash, 7 keygen.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_stage_mask  in  8  stages required by the command.
- cmd_ready  out  1  sequencer idle, can accept a command.
- start_processing  out  1  one-cycle pulse to the start FSM.
- start_processing_complete  in  1  parameters loaded.
- stage_start  out  8  one-hot, one-cycle start pulse per stage.
- stage_success  in  8  per-stage success or complete pulse.
- stage_fail  in  8  per-stage fail pulse; tied 0 for stages with no fail output.
- command_succeeded  out  1  one-cycle pulse to the done FSM.
- command_failed  out  1  one-cycle pulse to the error FSM.
- execution_complete_signal  in  1  level from the done FSM.
- execution_error_signal  in  1  level from the error FSM.
- control_ack  out  1  one-cycle acknowledge to the done/error FSMs.
- busy  out  1  high whenever state != IDLE.
- fail_stage  out  3  index of the failing or timed-out stage; 7 if the failure is in FETCH.
- fail_timeout  out  1  last failure was a watchdog timeout.
- stages_done  out  8  stages of the current command that completed successfully.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - cmd_ready=1, busy=0.
  - All pulse outputs 0.
  - fail_stage=0, fail_timeout=0, stages_done=0.
  - State IDLE, watchdog counter 0, pending mask 0.
- Reset taken mid-command returns to IDLE next edge with no further pulses.
- States: IDLE, FETCH, SELECT, WAIT, REPORT_OK, REPORT_ERR, ACK_OK, ACK_ERR.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge: latch mask into pending, clear stages_done/fail_stage/fail_timeout, start_processing=1 for exactly the next cycle, go to FETCH.
- FETCH:
  - On start_processing_complete go to SELECT.
  - Watchdog expiry: fail_stage=7, fail_timeout=1, go to REPORT_ERR.
- SELECT (one cycle):
  - If pending==0, go to REPORT_OK.
  - Otherwise idx = lowest set bit of pending; clear that bit; stage_start[idx]=1 for the next cycle only; go to WAIT.
- WAIT, monitoring only bit idx; responses on other bits are ignored:
  - stage_fail[idx]=1 (takes priority if stage_success[idx] is also 1): fail_stage=idx, fail_timeout=0, go to REPORT_ERR.
  - stage_success[idx]=1: stages_done[idx]=1, go to SELECT.
  - Watchdog expiry: fail_stage=idx, fail_timeout=1, go to REPORT_ERR.
  - A response in the same cycle stage_start is high is accepted.
- REPORT_OK: command_succeeded=1 for one cycle, then ACK_OK. REPORT_ERR: command_failed=1 for one cycle, then ACK_ERR.
- ACK_OK / ACK_ERR:
  - Wait for execution_complete_signal (OK) or execution_error_signal (ERR) to be 1.
  - On the edge sampling it, drive control_ack=1 for exactly the next cycle, then return to IDLE.
  - The sibling signal is ignored.
  - Watchdog expiry: return to IDLE without control_ack; fail_timeout=1 and fail_stage are left unchanged.
- Watchdog:
  - 16-bit counter, cleared on entry to FETCH, WAIT, ACK_OK and ACK_ERR; increments each cycle in those states.
  - Expiry when the counter equals TIMEOUT-1 with no qualifying input that cycle; a qualifying input in the expiry cycle wins.
- Empty mask (0): FETCH, then SELECT, then REPORT_OK; command_succeeded is pulsed with no stage started.
- cmd_valid is ignored while busy (no queue). Stage order is always bit 0 to bit 7.
- Minimum latency, full mask, all responses immediate: each stage costs 2 cycles.

Test Plan:
- Mask 0x41, params loaded after 3 cycles, auth success 2 cycles after its start, hash success 1 cycle after its start, done FSM acks -> start_processing pulse, then stage_start=0x01, then 0x40; command_succeeded one pulse; control_ack one pulse; stages_done=0x41; cmd_ready back to 1.
- Mask 0x0C, vm returns stage_fail -> stage_start=0x08 never pulses; command_failed one pulse; fail_stage=2; fail_timeout=0; control_ack after execution_error_signal.
- Mask 0x10, TIMEOUT=8, asym never responds -> command_failed exactly 8 cycles after stage_start pulse ends within WAIT entry; fail_stage=4; fail_timeout=1.
- Mask 0x01, stage_success[0] and stage_fail[0] together -> failure path, fail_stage=0; stage_success[5] pulsed during WAIT is ignored.
- Mask 0x00 -> command_succeeded with stage_start never nonzero; second cmd_valid during ACK_OK is not accepted.
- rst asserted during WAIT -> next cycle all outputs at reset values, cmd_ready=1, no command_succeeded/command_failed pulse.
